// File: rtl/dma_fifo.sv
// DMA byte/longword FIFO with byte assembly, flush sequencer and status flags.
// Optional sticky overrun flag enabled with `define DMA_FIFO_OVR_EN.
module dma_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST_,
    input  logic        DMADIR,
    input  logic        ACR_WR,
    input  logic        A1,
    input  logic        FLUSHFIFO,
    input  logic        BYTE_WR,
    input  logic        BYTE_RD,
    input  logic [7:0]  BYTE_IN,
    output logic [7:0]  BYTE_OUT,
    input  logic        LW_WR,
    input  logic        LW_RD,
    input  logic [31:0] LW_IN,
    output logic [31:0] LW_OUT,
    output logic        FIFOEMPTY,
    output logic        FIFOFULL,
    output logic        STOPFLUSH,
    output logic        OVR
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        PAD,
        DRAIN,
        DONE
    } state_t;

    logic [31:0] mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [1:0]  bp;
    logic [31:0] asm_q;
    logic [31:0] asm_wr;
    logic [31:0] pad_mask;
    logic [31:0] head;
    logic [31:0] push_data;
    logic [7:0]  head_byte;
    state_t      state;
    logic        flush_q;
    logic        stop_q;

    logic empty;
    logic full;
    logic in_pad;
    logic byte_wr_ok;
    logic byte_rd_ok;
    logic byte_push;
    logic byte_pop;
    logic pad_push;
    logic discard;
    logic lw_push;
    logic push;
    logic pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    // Byte strobes are owned by the flusher while it pads/discards; a full FIFO drops writes.
    assign in_pad     = (state == PAD);
    assign byte_wr_ok = BYTE_WR & ~DMADIR & ~in_pad & ~full;
    assign byte_rd_ok = BYTE_RD & DMADIR & ~in_pad & ~empty;
    assign byte_push  = byte_wr_ok & (bp == 2'd3);
    assign byte_pop   = byte_rd_ok & (bp == 2'd3);
    assign pad_push   = in_pad & ~DMADIR & (bp != 2'd0) & ~full;
    assign discard    = in_pad & DMADIR;
    assign pop        = ~ACR_WR & ~discard & ((LW_RD & ~empty) | byte_pop);
    assign lw_push    = LW_WR & (~full | pop);
    assign push       = ~ACR_WR & ~discard & (pad_push | byte_push | lw_push);

    // Insert the incoming byte into the assembly word, big-endian by byte pointer.
    always_comb begin
        asm_wr = asm_q;
        unique case (bp)
            2'd0: asm_wr[31:24] = BYTE_IN;
            2'd1: asm_wr[23:16] = BYTE_IN;
            2'd2: asm_wr[15:8]  = BYTE_IN;
            2'd3: asm_wr[7:0]   = BYTE_IN;
        endcase
    end

    // Keep only the bytes already written when padding a partial word.
    always_comb begin
        pad_mask = 32'h0;
        unique case (bp)
            2'd0: pad_mask = 32'h0000_0000;
            2'd1: pad_mask = 32'hFF00_0000;
            2'd2: pad_mask = 32'hFFFF_0000;
            2'd3: pad_mask = 32'hFFFF_FF00;
        endcase
    end

    // Select the head byte addressed by the byte pointer.
    always_comb begin
        head_byte = 8'h0;
        unique case (bp)
            2'd0: head_byte = head[31:24];
            2'd1: head_byte = head[23:16];
            2'd2: head_byte = head[15:8];
            2'd3: head_byte = head[7:0];
        endcase
    end

    // Pick the source for the single write port: pad, assembled bytes, then longword.
    always_comb begin
        push_data = LW_IN;
        if (pad_push) begin
            push_data = asm_q & pad_mask;
        end else if (byte_push) begin
            push_data = asm_wr;
        end
    end

    // Storage array write.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

    // Pointers, byte pointer and assembly register; ACR_WR re-initialises everything.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            wptr  <= '0;
            rptr  <= '0;
            bp    <= 2'd0;
            asm_q <= 32'h0;
        end else if (ACR_WR) begin
            wptr  <= '0;
            rptr  <= '0;
            bp    <= {A1, 1'b0};
            asm_q <= 32'h0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (discard) begin
                rptr <= wptr;
            end else if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            if (discard || pad_push) begin
                bp <= 2'd0;
            end else if (byte_wr_ok || byte_rd_ok) begin
                bp <= bp + 2'd1;
            end
            if (byte_wr_ok) begin
                asm_q <= asm_wr;
            end
        end
    end

    // Flush sequencer: pad or discard, wait for empty, then pulse STOPFLUSH once.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state   <= IDLE;
            flush_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            flush_q <= FLUSHFIFO;
            stop_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (FLUSHFIFO && !flush_q) begin
                        state <= PAD;
                    end
                end
                PAD: begin
                    if (ACR_WR) begin
                        state <= IDLE;
                    end else if (DMADIR) begin
                        state  <= DONE;
                        stop_q <= 1'b1;
                    end else if (bp == 2'd0 || !full) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ACR_WR) begin
                        state <= IDLE;
                    end else if (empty) begin
                        state  <= DONE;
                        stop_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMA_FIFO_OVR_EN
    logic ovr_q;

    // Sticky overrun: a byte write arrived while full and was dropped.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            ovr_q <= 1'b0;
        end else if (ACR_WR) begin
            ovr_q <= 1'b0;
        end else if (BYTE_WR && !DMADIR && !in_pad && full) begin
            ovr_q <= 1'b1;
        end
    end

    assign OVR = ovr_q;
`else
    assign OVR = 1'b0;
`endif

    assign FIFOEMPTY = empty;
    assign FIFOFULL  = full;
    assign STOPFLUSH = stop_q;
    assign LW_OUT    = empty ? 32'h0 : head;
    assign BYTE_OUT  = empty ? 8'h0 : head_byte;

endmodule
